stripe_n: RTL and testbench
===========================

Name: stripe_n

Overview:
- Parametrised N-lane byte-striping block for the transmit path, in the clk_2f domain.
- Collects consecutive valid input words round-robin into a group of NUM_LANES words and presents the whole group in parallel on the lane outputs.
- Each group is held for one lane slot of NUM_LANES cycles, feeding the per-lane serialisers.
- Successor to the two-lane striper: generalised lane count and width, with group alignment, partial-group flush with padding, and a slot timer.

Parameters:
- DATA_W, 32, width of input word and of each lane.
- NUM_LANES, 4, lane count; power of two, 2..8.
- PAD_WORD, 32'hBCBC_BCBC, value driven on lanes not filled by a flushed partial group (truncated to DATA_W).

Ports:
- clk_2f  input  1  single clock.
- reset  input  1  synchronous, active-low (0 = reset, sampled on the clk_2f rising edge).
- dataIn  input  DATA_W  input word.
- validIn  input  1  dataIn valid this cycle.
- lanes  output  NUM_LANES*DATA_W  flat lane bus; lane k occupies bits [k*DATA_W +: DATA_W].
- valid  output  NUM_LANES  per-lane valid.
- group_done  output  1  one-cycle pulse when a group is loaded onto the lanes.
- partial  output  1  the group currently on the lanes was a flushed partial group.

Behaviour:
- Reset (reset==0 at posedge):
  - lanes=0, valid=0, group_done=0, partial=0.
  - ptr=0, slot_cnt=0, shadow buffer=0, FSM to IDLE.
  - Reset mid-group discards the shadow contents; nothing is flushed.
- FSM has two states.
  - IDLE (ptr==0): validIn=1 stores dataIn in shadow[0], sets ptr=1 and moves to FILL. With NUM_LANES==2 the generic FILL rule applies from the next word.
  - FILL: each cycle with validIn=1 stores dataIn in shadow[ptr] and increments ptr.
- Full-group load: at the posedge where validIn=1 and ptr==NUM_LANES-1:
  - lanes[k] <= shadow[k] for k<NUM_LANES-1, and the last lane <= dataIn.
  - valid <= all ones, partial <= 0, group_done <= 1.
  - ptr wraps to 0 and the FSM returns to IDLE.
  - Latency is 1 cycle from the last word of a group to the lanes.
- Flush: at the posedge in FILL where validIn=0 (ptr!=0):
  - Lanes 0..ptr-1 load from shadow with valid=1.
  - Lanes ptr..NUM_LANES-1 load PAD_WORD with valid=0.
  - partial <= 1, group_done <= 1, ptr <= 0, FSM to IDLE.
- Slot timer:
  - On every load, slot_cnt <= NUM_LANES-1.
  - Otherwise, if slot_cnt!=0, slot_cnt decrements.
  - When slot_cnt==0 and no load occurs: valid <= 0 and partial <= 0. lanes holds its last data.
  - A continuous stream reloads exactly every NUM_LANES cycles, so valid stays constantly high.
- Simultaneous events: a load on the same edge that the slot timer expires takes priority, so valid never drops.
- IDLE with validIn=0: no state change apart from the slot timer.
- group_done is high for exactly one cycle per load.
- Lane order: the first word of a group always goes to lane 0.

Optional Feature:
- Macro: STRIPE_PARITY_EN.
- Defined:
  - Adds output lane_par [NUM_LANES-1:0], where lane_par[k] is the even parity (XOR reduction) of the word loaded into lane k.
  - It is registered with the lanes and loads on the same edge.
  - Padded lanes carry the parity of PAD_WORD.
  - Reset value is 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package stripe_pkg holds:
  - the FSM state typedef (ST_IDLE, ST_FILL);
  - the default PAD_WORD constant;
  - the function clog2 for the ptr and slot_cnt widths, which are $clog2(NUM_LANES).
- One sub-module, stripe_shadow: the NUM_LANES x DATA_W write-indexed shadow register file with synchronous clear.
- The FSM, the load path and the slot timer stay in stripe_n.

Test Plan:
All cases use NUM_LANES=4, DATA_W=32.
1. Full group: validIn=1 for 4 cycles with A0,A1,A2,A3.
   - One cycle after A3: lanes = {A3,A2,A1,A0}, valid=4'hF, group_done pulses once, partial=0.
   - valid falls 4 cycles after the load.
2. Back-to-back: 12 consecutive valid words.
   - Three loads at a 4-cycle period.
   - valid stays 4'hF continuously until 4 cycles after the third load.
3. Partial flush: 3 words B0,B1,B2, then validIn=0.
   - Next edge: lanes = {BCBCBCBC,B2,B1,B0}, valid=4'b0111, partial=1.
4. Reset mid-group: 2 words, then reset=0 for 1 cycle, then 4 words C0..C3.
   - Everything clears during reset and no flush occurs.
   - The next group lands C0 on lane 0.
5. Single word: validIn high for 1 cycle with D0.
   - Lane 0 = D0, valid=4'b0001.
   - Flush occurs 1 cycle after the word; group_done pulses once.
6. With STRIPE_PARITY_EN: group {32'h1,32'h3,32'h7,32'h0}.
   - lane_par = 4'b0101, with bit k belonging to lane k.

Source files
------------

// File: rtl/stripe_pkg.sv
// Shared types, constants and helpers for the stripe_n lane striper.
package stripe_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_FILL = 1'b1;

  localparam logic [31:0] PAD_WORD_DEFAULT = 32'hBCBC_BCBC;

  // Ceiling log2, used for the ptr and slot_cnt widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stripe_n_if.sv
// Bus bundle between a word source and the stripe_n lane striper.
// Optional lane_par signal present when STRIPE_PARITY_EN is defined.
interface stripe_n_if
  import stripe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4
);

  // dataIn is consumed on every rising edge where validIn=1; there is no
  // backpressure. valid[k]=1 marks lane k as carrying group data for the
  // current lane slot; group_done pulses once per group load.
  logic [DATA_W-1:0]           dataIn;
  logic                        validIn;
  logic [NUM_LANES*DATA_W-1:0] lanes;
  logic [NUM_LANES-1:0]        valid;
  logic                        group_done;
  logic                        partial;
  state_t                      dbg_state;
`ifdef STRIPE_PARITY_EN
  logic [NUM_LANES-1:0]        lane_par;
`endif

`ifdef STRIPE_PARITY_EN
  modport master (
    output dataIn, validIn,
    input  lanes, valid, group_done, partial, dbg_state, lane_par
  );
  modport slave (
    input  dataIn, validIn,
    output lanes, valid, group_done, partial, dbg_state, lane_par
  );
`else
  modport master (
    output dataIn, validIn,
    input  lanes, valid, group_done, partial, dbg_state
  );
  modport slave (
    input  dataIn, validIn,
    output lanes, valid, group_done, partial, dbg_state
  );
`endif

endinterface

// File: rtl/stripe_shadow.sv
// Write-indexed NUM_LANES x DATA_W shadow register file with synchronous
// clear; all entries are visible in parallel on a flat bus.
module stripe_shadow
  import stripe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int AW        = clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [NUM_LANES*DATA_W-1:0] words
);

  logic [DATA_W-1:0] mem [NUM_LANES];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_LANES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    words = '0;
    for (int i = 0; i < NUM_LANES; i++) words[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/stripe_n.sv
// N-lane round-robin word striper: collects NUM_LANES words, holds each group
// for one lane slot, flushes partial groups with padding.
// Optional per-lane parity output enabled by defining STRIPE_PARITY_EN.
module stripe_n
  import stripe_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_LANES = 4,
  parameter logic [31:0] PAD_WORD  = PAD_WORD_DEFAULT
) (
  input  logic       clk_2f,
  input  logic       reset,
  stripe_n_if.slave  bus
);

  localparam int                PW   = clog2(NUM_LANES);
  localparam logic [PW-1:0]     LAST = PW'(NUM_LANES - 1);
  localparam logic [DATA_W-1:0] PAD  = DATA_W'(PAD_WORD);

  state_t                      state, state_nxt;
  logic [PW-1:0]               ptr;
  logic [PW-1:0]               slot_cnt;
  logic [NUM_LANES*DATA_W-1:0] shadow_words;
  logic [NUM_LANES*DATA_W-1:0] lanes_q, lanes_nxt;
  logic [NUM_LANES-1:0]        valid_q, valid_nxt;
  logic                        group_done_q;
  logic                        partial_q;
  logic                        do_full, do_flush, do_load;
`ifdef STRIPE_PARITY_EN
  logic [NUM_LANES-1:0]        par_q, par_nxt;
`endif

  assign do_full  = bus.validIn && (ptr == LAST);
  assign do_flush = (state == ST_FILL) && !bus.validIn;
  assign do_load  = do_full || do_flush;

  // The last word of a full group bypasses the shadow straight onto its lane.
  stripe_shadow #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .AW        (PW)
  ) u_shadow (
    .clk   (clk_2f),
    .clr   (!reset),
    .we    (bus.validIn && !do_full),
    .waddr (ptr),
    .wdata (bus.dataIn),
    .words (shadow_words)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.validIn) state_nxt = ST_FILL;
      ST_FILL: if (do_load) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    lanes_nxt = '0;
    valid_nxt = '0;
`ifdef STRIPE_PARITY_EN
    par_nxt   = '0;
`endif
    for (int k = 0; k < NUM_LANES; k++) begin
      logic [DATA_W-1:0] word;
      logic              lane_ok;
      word    = PAD;
      lane_ok = 1'b0;
      if (do_full) begin
        word    = (k == NUM_LANES - 1) ? bus.dataIn : shadow_words[k*DATA_W +: DATA_W];
        lane_ok = 1'b1;
      end else if (k < int'(ptr)) begin
        word    = shadow_words[k*DATA_W +: DATA_W];
        lane_ok = 1'b1;
      end
      lanes_nxt[k*DATA_W +: DATA_W] = word;
      valid_nxt[k]                  = lane_ok;
`ifdef STRIPE_PARITY_EN
      par_nxt[k]                    = ^word;
`endif
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      slot_cnt     <= '0;
      lanes_q      <= '0;
      valid_q      <= '0;
      group_done_q <= 1'b0;
      partial_q    <= 1'b0;
`ifdef STRIPE_PARITY_EN
      par_q        <= '0;
`endif
    end else begin
      state        <= state_nxt;
      group_done_q <= do_load;
      if (do_load) begin
        ptr       <= '0;
        lanes_q   <= lanes_nxt;
        valid_q   <= valid_nxt;
        partial_q <= do_flush;
        slot_cnt  <= LAST;
`ifdef STRIPE_PARITY_EN
        par_q     <= par_nxt;
`endif
      end else begin
        if (bus.validIn) ptr <= ptr + PW'(1);
        // Lane data is held after the slot ends; only the qualifiers drop.
        if (slot_cnt != '0) begin
          slot_cnt <= slot_cnt - PW'(1);
        end else begin
          valid_q   <= '0;
          partial_q <= 1'b0;
        end
      end
    end
  end

  assign bus.lanes      = lanes_q;
  assign bus.valid      = valid_q;
  assign bus.group_done = group_done_q;
  assign bus.partial    = partial_q;
  assign bus.dbg_state  = state;
`ifdef STRIPE_PARITY_EN
  assign bus.lane_par   = par_q;
`endif

endmodule

// File: tb/tb_stripe_n.sv
// Directed self-checking bench for stripe_n with NUM_LANES=4, DATA_W=32.
module tb_stripe_n;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int BW        = NUM_LANES * DATA_W;
  localparam logic [31:0] PAD = 32'hBCBC_BCBC;

  logic clk_2f;
  logic reset;

  stripe_n_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) bus ();

  stripe_n #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every group_done pulse must match the oldest expected group.
  always @(negedge clk_2f) begin
    if (reset && bus.group_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_group", bus.lanes, '1);
      end else begin
        check("sb_group", bus.lanes, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic v);
    bus.dataIn  = w;
    bus.validIn = v;
    tick();
  endtask

  task automatic send_group(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    exp_q.push_back({w3, w2, w1, w0});
    drive(w0, 1'b1);
    drive(w1, 1'b1);
    drive(w2, 1'b1);
    drive(w3, 1'b1);
  endtask

  task automatic drain(input logic [3:0] held_valid, input string tag);
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0);
      check({tag, "_valid_held"}, BW'(bus.valid), BW'(held_valid));
    end
    drive('0, 1'b0);
    check({tag, "_valid_drop"}, BW'(bus.valid), '0);
    check({tag, "_partial_drop"}, BW'(bus.partial), '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset       = 1'b0;
    bus.dataIn  = '0;
    bus.validIn = 1'b0;
    tick();
    tick();
    check("rst_lanes", bus.lanes, '0);
    check("rst_valid", BW'(bus.valid), '0);
    check("rst_done", BW'(bus.group_done), '0);
    check("rst_partial", BW'(bus.partial), '0);
    check("rst_state", BW'(bus.dbg_state), '0);
    reset = 1'b1;
    tick();

    // 1. Full group.
    send_group(32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333);
    check("t1_lanes", bus.lanes, {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000});
    check("t1_valid", BW'(bus.valid), BW'(4'hF));
    check("t1_done", BW'(bus.group_done), 1);
    check("t1_partial", BW'(bus.partial), '0);
    drive('0, 1'b0);
    check("t1_done_once", BW'(bus.group_done), '0);
    drive('0, 1'b0);
    drive('0, 1'b0);
    check("t1_valid_held", BW'(bus.valid), BW'(4'hF));
    drive('0, 1'b0);
    check("t1_valid_drop", BW'(bus.valid), '0);
    check("t1_lanes_kept", bus.lanes, {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000});

    // 2. Back-to-back: 12 words, three loads at a 4-cycle period.
    for (int g = 0; g < 3; g++) begin
      exp_q.push_back({32'h2000_0000 + g*4 + 3, 32'h2000_0000 + g*4 + 2,
                       32'h2000_0000 + g*4 + 1, 32'h2000_0000 + g*4});
    end
    for (int i = 0; i < 12; i++) begin
      drive(32'h2000_0000 + i, 1'b1);
      check("t2_done", BW'(bus.group_done), BW'((i % 4) == 3));
      if (i >= 3) check("t2_valid_cont", BW'(bus.valid), BW'(4'hF));
    end
    check("t2_lanes", bus.lanes, {32'h2000_000B, 32'h2000_000A, 32'h2000_0009, 32'h2000_0008});
    drain(4'hF, "t2");

    // 3. Partial flush of three words.
    exp_q.push_back({PAD, 32'hB222_2222, 32'hB111_1111, 32'hB000_0000});
    drive(32'hB000_0000, 1'b1);
    drive(32'hB111_1111, 1'b1);
    drive(32'hB222_2222, 1'b1);
    check("t3_no_early_load", BW'(bus.group_done), '0);
    drive('0, 1'b0);
    check("t3_lanes", bus.lanes, {PAD, 32'hB222_2222, 32'hB111_1111, 32'hB000_0000});
    check("t3_valid", BW'(bus.valid), BW'(4'b0111));
    check("t3_partial", BW'(bus.partial), 1);
    check("t3_done", BW'(bus.group_done), 1);
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0);
      check("t3_partial_held", BW'(bus.partial), 1);
    end
    drive('0, 1'b0);
    check("t3_valid_drop", BW'(bus.valid), '0);
    check("t3_partial_drop", BW'(bus.partial), '0);

    // 4. Reset mid-group discards the shadow; next group starts at lane 0.
    drive(32'hEEEE_0000, 1'b1);
    drive(32'hEEEE_1111, 1'b1);
    reset       = 1'b0;
    bus.validIn = 1'b0;
    tick();
    check("t4_rst_lanes", bus.lanes, '0);
    check("t4_rst_valid", BW'(bus.valid), '0);
    check("t4_rst_done", BW'(bus.group_done), '0);
    check("t4_rst_state", BW'(bus.dbg_state), '0);
    reset = 1'b1;
    send_group(32'hC000_0000, 32'hC111_1111, 32'hC222_2222, 32'hC333_3333);
    check("t4_lanes", bus.lanes, {32'hC333_3333, 32'hC222_2222, 32'hC111_1111, 32'hC000_0000});
    check("t4_partial", BW'(bus.partial), '0);
    drain(4'hF, "t4");

    // 5. Single word flushed one cycle later.
    exp_q.push_back({PAD, PAD, PAD, 32'hD000_000D});
    drive(32'hD000_000D, 1'b1);
    check("t5_no_done_yet", BW'(bus.group_done), '0);
    drive('0, 1'b0);
    check("t5_lanes", bus.lanes, {PAD, PAD, PAD, 32'hD000_000D});
    check("t5_valid", BW'(bus.valid), BW'(4'b0001));
    check("t5_partial", BW'(bus.partial), 1);
    check("t5_done", BW'(bus.group_done), 1);
    drive('0, 1'b0);
    check("t5_done_once", BW'(bus.group_done), '0);
    drive('0, 1'b0);
    drive('0, 1'b0);
    drive('0, 1'b0);
    check("t5_valid_drop", BW'(bus.valid), '0);

    // 6. Parity group.
    send_group(32'h0000_0001, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000);
    check("t6_lanes", bus.lanes, {32'h0, 32'h7, 32'h3, 32'h1});
`ifdef STRIPE_PARITY_EN
    check("t6_lane_par", BW'(bus.lane_par), BW'(4'b0101));
`endif
    drain(4'hF, "t6");

    check("sb_drained", BW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
